// File: rtl/spi_tx_scheduler.sv
// FIFO-fed sequencer for the SPI TX engine: consecutive data bytes share one CS-low burst,
// and every command byte is its own transaction. Optional delay markers: `SPI_TX_DELAY_EN.
module spi_tx_scheduler #(
    parameter int unsigned DEPTH      = 16,
    parameter int unsigned GAP_CYCLES = 4,
    parameter int unsigned DELAY_UNIT = 1000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       wr_en,
    input  logic       wr_dc,
    input  logic       wr_delay,
    input  logic [7:0] wr_data,
    input  logic [7:0] prescaler,
    output logic       full,
    output logic       empty,
    output logic       busy,
    output logic       ovf,
    output logic [9:0] spi_control,
    output logic [7:0] spi_data,
    input  logic       spi_valid,
    input  logic       spi_cs
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam int unsigned GW = $clog2(GAP_CYCLES + 1);

`ifdef SPI_TX_DELAY_EN
    localparam int unsigned EW = 10;
    localparam int unsigned DW = $clog2(255 * DELAY_UNIT + 1);
    typedef enum logic [1:0] {IDLE, XFER, GAP, DELAY} state_t;
`else
    localparam int unsigned EW = 9;
    typedef enum logic [1:0] {IDLE, XFER, GAP} state_t;
`endif

    state_t        state;
    logic [EW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic [GW-1:0] gap_cnt;
    logic [EW-1:0] head;
    logic [EW-1:0] wr_entry;
    logic [7:0]    head_data;
    logic          head_dc;
    logic          head_delay;
    logic          push;
    logic          pop;

    assign head      = mem[rd_ptr];
    assign head_data = head[7:0];
    assign head_dc   = head[8];

`ifdef SPI_TX_DELAY_EN
    logic [DW-1:0] delay_cnt;
    assign head_delay = head[9];
    assign wr_entry   = {wr_delay, wr_dc, wr_data};
`else
    logic unused_cfg;
    assign head_delay = 1'b0;
    assign wr_entry   = {wr_dc, wr_data};
    assign unused_cfg = wr_delay ^ DELAY_UNIT[0];
`endif

    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);
    assign busy  = (state != IDLE) || !empty;

    // 'full' is the pre-edge value, so a write while full is dropped even alongside a pop
    assign push = wr_en && !full;

    // Pop on transaction start, or to extend a data burst with a data head
    always_comb begin
        pop = 1'b0;
        case (state)
            IDLE:    pop = !empty;
            XFER:    pop = spi_valid && spi_control[1] && !empty && head_dc && !head_delay;
            default: pop = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wr_entry;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= IDLE;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            ovf         <= 1'b0;
            spi_control <= '0;
            spi_data    <= '0;
            gap_cnt     <= '0;
`ifdef SPI_TX_DELAY_EN
            delay_cnt   <= '0;
`endif
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(push) - CW'(pop);
            if (wr_en && full) ovf <= 1'b1;

            case (state)
                IDLE: begin
                    if (!empty) begin
`ifdef SPI_TX_DELAY_EN
                        if (head_delay) begin
                            spi_control[0] <= 1'b0;
                            delay_cnt      <= DW'(head_data) * DW'(DELAY_UNIT);
                            state          <= DELAY;
                        end else begin
                            spi_data    <= head_data;
                            spi_control <= {prescaler, head_dc, 1'b1};
                            state       <= XFER;
                        end
`else
                        spi_data    <= head_data;
                        spi_control <= {prescaler, head_dc, 1'b1};
                        state       <= XFER;
`endif
                    end
                end
                XFER: begin
                    if (spi_valid) begin
                        if (pop) begin
                            spi_data <= head_data;
                        end else begin
                            spi_control[0] <= 1'b0;
                            gap_cnt        <= '0;
                            state          <= GAP;
                        end
                    end
                end
                GAP: begin
                    // Any cycle with CS low restarts the idle-time count
                    if (!spi_cs) begin
                        gap_cnt <= '0;
                    end else if (gap_cnt == GW'(GAP_CYCLES - 1)) begin
                        gap_cnt <= '0;
                        state   <= IDLE;
                    end else begin
                        gap_cnt <= gap_cnt + GW'(1);
                    end
                end
`ifdef SPI_TX_DELAY_EN
                DELAY: begin
                    // A zero count still spends one cycle here
                    if (delay_cnt <= DW'(1)) begin
                        state <= IDLE;
                    end else begin
                        delay_cnt <= delay_cnt - DW'(1);
                    end
                end
`endif
                default: state <= IDLE;
            endcase
        end
    end

endmodule
